// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-memory port between the CPU core and the
// program loader/debug master. Every access runs IDLE -> ISSUE -> (read: WAIT x RD_LAT
// -> RESP) -> IDLE. The core wins ties unless the loader has been passed over
// STARVE_LIM times in a row.
// Optional feature: define MEM_ARB_ADDR_GUARD_EN to block core writes into the text
// segment [TEXT_BASE, TEXT_BASE+TEXT_SIZE). A blocked write is still granted, but it
// reaches RAM with mem_we=0 and raises err.
module mem_port_arbiter #(
    parameter int            AW         = 16,
    parameter int            DW         = 16,
    parameter int            RD_LAT     = 1,
    parameter int            STARVE_LIM = 4,
    parameter logic [AW-1:0] TEXT_BASE  = AW'('h2800),
    parameter logic [AW-1:0] TEXT_SIZE  = AW'('h1000)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SCW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_winL;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_blocked;
    logic [WCW-1:0]   r_waitCnt;
    logic [SCW-1:0]   r_starveCnt;
    logic [DW-1:0]    r_cRdata;
    logic [DW-1:0]    r_lRdata;

    logic             w_anyReq;
    logic             w_pickLoader;
    logic             w_waitDone;
    logic             w_guardHit;

    assign w_anyReq     = c_req | l_req;
    assign w_pickLoader = l_req & (~c_req | (r_starveCnt == SCW'(STARVE_LIM)));
    assign w_waitDone   = (r_waitCnt == WCW'(RD_LAT - 1));

`ifdef MEM_ARB_ADDR_GUARD_EN
    // The segment end is formed one bit wider so a segment touching the top of the
    // address space does not wrap around to zero.
    logic [AW:0] w_textEnd;
    assign w_textEnd  = {1'b0, TEXT_BASE} + {1'b0, TEXT_SIZE};
    assign w_guardHit = ~w_pickLoader & c_we &
                        ({1'b0, c_addr} >= {1'b0, TEXT_BASE}) &
                        ({1'b0, c_addr} <  w_textEnd);
`else
    assign w_guardHit = 1'b0;
`endif

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: writes finish right after ISSUE, reads wait RD_LAT cycles then respond.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_anyReq) w_nextState = S_ISSUE;
            S_ISSUE: w_nextState = r_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (w_waitDone) w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: latch the winning request, track loader starvation, count read wait cycles
    // and capture the RAM data into the winner's read-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winL      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_blocked   <= 1'b0;
            r_waitCnt   <= '0;
            r_starveCnt <= '0;
            r_cRdata    <= '0;
            r_lRdata    <= '0;
        end else begin
            if (r_state == S_IDLE && w_anyReq) begin
                r_winL    <= w_pickLoader;
                r_we      <= w_pickLoader ? l_we    : c_we;
                r_addr    <= w_pickLoader ? l_addr  : c_addr;
                r_wdata   <= w_pickLoader ? l_wdata : c_wdata;
                r_blocked <= w_guardHit;
                if (w_pickLoader) begin
                    r_starveCnt <= '0;
                end else if (l_req && r_starveCnt != SCW'(STARVE_LIM)) begin
                    r_starveCnt <= r_starveCnt + 1'b1;
                end
            end
            if (r_state == S_ISSUE) begin
                r_waitCnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (r_state == S_WAIT && w_waitDone) begin
                if (r_winL) begin
                    r_lRdata <= mem_rdata;
                end else begin
                    r_cRdata <= mem_rdata;
                end
            end
        end
    end

    // Outputs decoded from state: RAM strobe and grant in ISSUE, read-valid in RESP.
    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        l_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        err       = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_we & ~r_blocked;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                c_gnt     = ~r_winL;
                l_gnt     = r_winL;
                err       = r_blocked;
            end
            S_RESP: begin
                c_rvalid = ~r_winL;
                l_rvalid = r_winL;
            end
            default: ;
        endcase
    end

    assign c_rdata = r_cRdata;
    assign l_rdata = r_lRdata;

endmodule
